// File: rtl/conv2d_engine.sv
// conv2d_engine: direct 2-D convolution, one multiply-accumulate per cycle.
// Ports: clk, rst (async, active high); start, relu_en, busy, done control;
//   img_addr/img_data and wgt_addr/wgt_data read ports (1-cycle latency);
//   out_valid/out_addr/out_data result write port.
module conv2d_engine #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int K      = 3,
   parameter int IN_W   = 8,
   parameter int IN_H   = 8,
   parameter int CH     = 1,
   localparam int OH    = IN_H - K + 1,
   localparam int OW    = IN_W - K + 1,
   localparam int IA_W  = (CH*IN_H*IN_W > 1) ? $clog2(CH*IN_H*IN_W) : 1,
   localparam int WA_W  = (CH*K*K > 1) ? $clog2(CH*K*K) : 1,
   localparam int OA_W  = (OH*OW > 1) ? $clog2(OH*OW) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              relu_en,
   output logic              busy,
   output logic              done,
   output logic [IA_W-1:0]   img_addr,
   input  logic [DATA_W-1:0] img_data,
   output logic [WA_W-1:0]   wgt_addr,
   input  logic [DATA_W-1:0] wgt_data,
   output logic              out_valid,
   output logic [OA_W-1:0]   out_addr,
   output logic [ACC_W-1:0]  out_data
);

   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
   localparam int KW  = (K > 1) ? $clog2(K) : 1;
   localparam int RW  = (OH > 1) ? $clog2(OH) : 1;
   localparam int CW  = (OW > 1) ? $clog2(OW) : 1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      WRITE,
      DONE
   } state_t;

   state_t state, state_n;

   logic [CHW-1:0] ch_q, ch_n;
   logic [KW-1:0]  ky_q, ky_n;
   logic [KW-1:0]  kx_q, kx_n;
   logic [RW-1:0]  r_q, r_n;
   logic [CW-1:0]  c_q, c_n;
   logic           load;
   logic           relu_q;
   logic           first_tap;
   logic           last_tap;
   logic           last_px;

   logic [IA_W-1:0] img_addr_n;
   logic [WA_W-1:0] wgt_addr_n;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    acc;

   assign busy = (state != IDLE);

   assign first_tap = (ch_q == '0) && (ky_q == '0) && (kx_q == '0);
   assign last_tap  = (ch_q == CHW'(CH-1)) && (ky_q == KW'(K-1))
                      && (kx_q == KW'(K-1));
   assign last_px   = (r_q == RW'(OH-1)) && (c_q == CW'(OW-1));

   always_comb begin
      prod     = $signed(img_data) * $signed(wgt_data);
      prod_ext = ACC_W'(prod);
   end

   // Counters always describe the tap whose address is on the bus;
   // load marks edges where the address registers move to the next tap.
   always_comb begin
      state_n = state;
      ch_n    = ch_q;
      ky_n    = ky_q;
      kx_n    = kx_q;
      r_n     = r_q;
      c_n     = c_q;
      load    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = FETCH;
               ch_n    = '0;
               ky_n    = '0;
               kx_n    = '0;
               r_n     = '0;
               c_n     = '0;
               load    = 1'b1;
            end
         end
         FETCH: begin
            if (last_tap) begin
               state_n = DRAIN;
            end else begin
               load = 1'b1;
               if (kx_q == KW'(K-1)) begin
                  kx_n = '0;
                  if (ky_q == KW'(K-1)) begin
                     ky_n = '0;
                     ch_n = ch_q + CHW'(1);
                  end else begin
                     ky_n = ky_q + KW'(1);
                  end
               end else begin
                  kx_n = kx_q + KW'(1);
               end
            end
         end
         DRAIN: state_n = WRITE;
         WRITE: begin
            ch_n = '0;
            ky_n = '0;
            kx_n = '0;
            if (last_px) begin
               state_n = DONE;
            end else begin
               state_n = FETCH;
               load    = 1'b1;
               if (c_q == CW'(OW-1)) begin
                  c_n = '0;
                  r_n = r_q + RW'(1);
               end else begin
                  c_n = c_q + CW'(1);
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      img_addr_n = IA_W'(int'(ch_n)*IN_H*IN_W
                         + (int'(r_n) + int'(ky_n))*IN_W
                         + int'(c_n) + int'(kx_n));
      wgt_addr_n = WA_W'(int'(ch_n)*K*K + int'(ky_n)*K + int'(kx_n));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ch_q      <= '0;
         ky_q      <= '0;
         kx_q      <= '0;
         r_q       <= '0;
         c_q       <= '0;
         relu_q    <= 1'b0;
         acc       <= '0;
         img_addr  <= '0;
         wgt_addr  <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         done      <= 1'b0;
      end else begin
         state <= state_n;
         ch_q  <= ch_n;
         ky_q  <= ky_n;
         kx_q  <= kx_n;
         r_q   <= r_n;
         c_q   <= c_n;
         if (load) begin
            img_addr <= img_addr_n;
            wgt_addr <= wgt_addr_n;
         end
         if (state == IDLE && start) begin
            relu_q <= relu_en;
         end
         // Data seen in the first FETCH cycle belongs to no tap of this
         // pixel, so that cycle clears instead of accumulating.
         if (state == FETCH) begin
            acc <= first_tap ? '0 : acc + prod_ext;
         end else if (state == DRAIN) begin
            acc <= acc + prod_ext;
         end
         out_valid <= (state == WRITE);
         done      <= (state == DONE);
         if (state == WRITE) begin
            out_addr <= OA_W'(int'(r_q)*OW + int'(c_q));
            out_data <= (relu_q && acc[ACC_W-1]) ? '0 : acc;
         end
      end
   end

endmodule
